// File: rtl/game_pkg.sv
// Shared game-state types for the screen sequencer and its neighbours.
// Horizontal/vertical timing constants live in vga_pkg, not here.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    typedef enum logic {
        SINGLE = 1'b0,
        MULTI  = 1'b1
    } mode_t;

    localparam int STEP_W = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vblnk_edge.sv
// Registered rising-edge detector on vblnk; emits a one-cycle frame_start.
// A vblnk level already high when reset releases does not count as an edge.
module vblnk_edge (
    input  logic clk65MHz,
    input  logic rst_n,
    input  logic vblnk,
    output logic frame_start
);

    logic vblnk_p0;
    logic armed_p0;

    // armed_p0 masks the first cycle after reset so a high vblnk is first sampled, not edge-detected
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_p0    <= 1'b0;
            armed_p0    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vblnk_p0    <= vblnk;
            armed_p0    <= 1'b1;
            frame_start <= vblnk & ~vblnk_p0 & armed_p0;
        end
    end

endmodule

// File: rtl/screen_mode_ctrl.sv
// Frame-synchronous game-state sequencer: selects the background screen,
// runs the pre-game countdown and gates gameplay; changes land only at frame start.
module screen_mode_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 60,
    parameter int COUNT_STEPS     = 3,
    parameter int GAMEOVER_FRAMES = 120
) (
    input  logic              clk65MHz,
    input  logic              rst_n,
    input  logic              vblnk,
    input  logic              start_single,
    input  logic              start_multi,
    input  logic              game_over,
    input  logic              abort,
    output logic              screen_single,
    output logic              screen_multi,
    output logic              game_run,
    output logic [STEP_W-1:0] countdown_val,
    output logic              frame_start
);

    localparam int FRAME_MAX = max_int(FRAMES_PER_STEP, GAMEOVER_FRAMES);
    localparam int CNT_W     = $clog2(FRAME_MAX + 1);

    localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0]  GO_LAST    = CNT_W'(GAMEOVER_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEPS_INIT = STEP_W'(COUNT_STEPS);

    state_t            state_q, state_n;
    mode_t             mode_q, mode_n;
    logic [STEP_W-1:0] step_q, step_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    logic pend_single_q, pend_single_n;
    logic pend_multi_q, pend_multi_n;
    logic pend_go_q, pend_go_n;
    logic pend_abort_q, pend_abort_n;

    logic req_single, req_multi, req_go, req_abort;
    logic in_idle;

    vblnk_edge u_vblnk_edge (
        .clk65MHz    (clk65MHz),
        .rst_n       (rst_n),
        .vblnk       (vblnk),
        .frame_start (frame_start)
    );

    // A pulse arriving on the frame_start cycle is merged with its pending flag and consumed at once
    assign req_single = pend_single_q | start_single;
    assign req_multi  = pend_multi_q  | start_multi;
    assign req_go     = pend_go_q     | game_over;
    assign req_abort  = pend_abort_q  | abort;
    assign in_idle    = (state_q == IDLE);

    always_comb begin
        state_n       = state_q;
        mode_n        = mode_q;
        step_n        = step_q;
        cnt_n         = cnt_q;
        pend_single_n = 1'b0;
        pend_multi_n  = 1'b0;
        pend_go_n     = 1'b0;
        pend_abort_n  = 1'b0;

        if (!frame_start) begin
            // Requests not acceptable in the current state are dropped here and never replayed
            pend_single_n = in_idle & req_single;
            pend_multi_n  = in_idle & req_multi;
            pend_go_n     = (state_q == PLAY) & req_go;
            pend_abort_n  = ~in_idle & req_abort;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_single || req_multi) begin
                        state_n = COUNTDOWN;
                        mode_n  = req_single ? SINGLE : MULTI;
                        step_n  = STEPS_INIT;
                        cnt_n   = '0;
                    end
                end
                COUNTDOWN: begin
                    if (req_abort) begin
                        state_n = IDLE;
                        step_n  = '0;
                        cnt_n   = '0;
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_n = '0;
                        if (step_q == STEP_W'(1)) begin
                            state_n = PLAY;
                            step_n  = '0;
                        end else begin
                            step_n = step_q - STEP_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (req_abort) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (req_go) begin
                        state_n = GAME_OVER;
                        cnt_n   = '0;
                    end
                end
                GAME_OVER: begin
                    if (req_abort || cnt_q == GO_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    step_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= SINGLE;
            step_q        <= '0;
            cnt_q         <= '0;
            pend_single_q <= 1'b0;
            pend_multi_q  <= 1'b0;
            pend_go_q     <= 1'b0;
            pend_abort_q  <= 1'b0;
        end else begin
            state_q       <= state_n;
            mode_q        <= mode_n;
            step_q        <= step_n;
            cnt_q         <= cnt_n;
            pend_single_q <= pend_single_n;
            pend_multi_q  <= pend_multi_n;
            pend_go_q     <= pend_go_n;
            pend_abort_q  <= pend_abort_n;
        end
    end

    // Outputs decode the next state so they update on the same edge as the state register
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            screen_single <= 1'b0;
            screen_multi  <= 1'b0;
            game_run      <= 1'b0;
            countdown_val <= '0;
        end else begin
            screen_single <= (state_n != IDLE) && (mode_n == SINGLE);
            screen_multi  <= (state_n != IDLE) && (mode_n == MULTI);
            game_run      <= (state_n == PLAY);
            countdown_val <= (state_n == COUNTDOWN) ? step_n : '0;
        end
    end

endmodule

// File: tb/tb_screen_mode_ctrl.sv
// Directed bench for screen_mode_ctrl with FRAMES_PER_STEP=2, COUNT_STEPS=3, GAMEOVER_FRAMES=4.
module tb_screen_mode_ctrl;

    logic       clk65MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       vblnk = 1'b0;
    logic       start_single = 1'b0;
    logic       start_multi = 1'b0;
    logic       game_over = 1'b0;
    logic       abort = 1'b0;
    logic       screen_single;
    logic       screen_multi;
    logic       game_run;
    logic [3:0] countdown_val;
    logic       frame_start;

    int tests = 0;
    int failed = 0;

    screen_mode_ctrl #(
        .FRAMES_PER_STEP (2),
        .COUNT_STEPS     (3),
        .GAMEOVER_FRAMES (4)
    ) dut (
        .clk65MHz      (clk65MHz),
        .rst_n         (rst_n),
        .vblnk         (vblnk),
        .start_single  (start_single),
        .start_multi   (start_multi),
        .game_over     (game_over),
        .abort         (abort),
        .screen_single (screen_single),
        .screen_multi  (screen_multi),
        .game_run      (game_run),
        .countdown_val (countdown_val),
        .frame_start   (frame_start)
    );

    always #8 clk65MHz = ~clk65MHz;

    // Frame: 16 cycles active, 4 cycles blanking
    initial begin
        forever begin
            repeat (16) @(negedge clk65MHz);
            vblnk = 1'b1;
            repeat (4) @(negedge clk65MHz);
            vblnk = 1'b0;
        end
    end

    // Returns at the negedge after the frame_start cycle, when the registered outputs have updated
    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk65MHz);
        while (frame_start !== 1'b1 && n < 200) begin
            @(negedge clk65MHz);
            n++;
        end
        tests++;
        if (n >= 200) begin
            failed++;
            $display("FAIL wait_fs: frame_start=%b after %0d cycles, required 1", frame_start, n);
        end
        @(negedge clk65MHz);
    endtask

    task automatic wait_frames(input int k);
        for (int i = 0; i < k; i++) wait_fs();
    endtask

    task automatic pulse(input logic s, input logic m, input logic g, input logic a);
        start_single = s;
        start_multi  = m;
        game_over    = g;
        abort        = a;
        @(negedge clk65MHz);
        start_single = 1'b0;
        start_multi  = 1'b0;
        game_over    = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic es, input logic em,
                              input logic er, input logic [3:0] ec);
        tests++;
        if (screen_single !== es || screen_multi !== em || game_run !== er || countdown_val !== ec) begin
            failed++;
            $display("FAIL %s: single=%b multi=%b run=%b cd=%0d, required single=%b multi=%b run=%b cd=%0d",
                     name, screen_single, screen_multi, game_run, countdown_val, es, em, er, ec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk65MHz);
        expect_out("reset_outputs", 1'b0, 1'b0, 1'b0, 4'd0);
        tests++;
        if (frame_start !== 1'b0) begin
            failed++;
            $display("FAIL reset_frame_start: got %b, required 0", frame_start);
        end
        rst_n = 1'b1;
        wait_fs();
        expect_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_single_start();
        repeat (5) @(negedge clk65MHz);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("pending_no_change", 1'b0, 1'b0, 1'b0, 4'd0);
        wait_fs();
        expect_out("countdown_3", 1'b1, 1'b0, 1'b0, 4'd3);
        wait_frames(2);
        expect_out("countdown_2", 1'b1, 1'b0, 1'b0, 4'd2);
        wait_frames(2);
        expect_out("countdown_1", 1'b1, 1'b0, 1'b0, 4'd1);
        wait_frames(1);
        expect_out("countdown_1_hold", 1'b1, 1'b0, 1'b0, 4'd1);
        wait_frames(1);
        expect_out("play_single", 1'b1, 1'b0, 1'b1, 4'd0);
    endtask

    task automatic test_game_over();
        repeat (3) @(negedge clk65MHz);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("go_wait_frame", 1'b1, 1'b0, 1'b1, 4'd0);
        wait_fs();
        expect_out("game_over_screen", 1'b1, 1'b0, 1'b0, 4'd0);
        wait_frames(3);
        expect_out("game_over_hold", 1'b1, 1'b0, 1'b0, 4'd0);
        wait_frames(1);
        expect_out("game_over_to_idle", 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        wait_fs();
        expect_out("simul_single_wins", 1'b1, 1'b0, 1'b0, 4'd3);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_fs();
        expect_out("abort_countdown", 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_abort_vs_game_over();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_fs();
        expect_out("multi_countdown", 1'b0, 1'b1, 1'b0, 4'd3);
        wait_frames(6);
        expect_out("play_multi", 1'b0, 1'b1, 1'b1, 4'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        wait_fs();
        expect_out("abort_beats_go", 1'b0, 1'b0, 1'b0, 4'd0);
        wait_fs();
        expect_out("no_game_over_frames", 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_rejected();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_frames(7);
        expect_out("play_for_reject", 1'b1, 1'b0, 1'b1, 4'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_fs();
        expect_out("multi_in_play_ignored", 1'b1, 1'b0, 1'b1, 4'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_fs();
        expect_out("abort_play", 1'b0, 1'b0, 1'b0, 4'd0);
        wait_frames(2);
        expect_out("multi_not_replayed", 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_frames(2);
        expect_out("go_in_idle_ignored", 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_frames(2);
        expect_out("abort_in_idle_ignored", 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_reset_mid_countdown();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_fs();
        wait_frames(2);
        expect_out("mid_countdown_2", 1'b1, 1'b0, 1'b0, 4'd2);
        repeat (3) @(negedge clk65MHz);
        rst_n = 1'b0;
        #1;
        expect_out("async_reset_outputs", 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) @(negedge clk65MHz);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_fs();
            expect_out("idle_after_mid_reset", 1'b0, 1'b0, 1'b0, 4'd0);
        end
    endtask

    task automatic test_vblnk_high_reset();
        int seen;
        wait_fs();
        rst_n = 1'b0;
        @(negedge clk65MHz);
        rst_n = 1'b1;
        seen = 0;
        while (vblnk === 1'b1) begin
            @(negedge clk65MHz);
            if (frame_start === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL vblnk_high_release: frame_start pulses=%0d, required 0", seen);
        end
        wait_fs();
        expect_out("idle_after_high_release", 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_single_start();
        test_game_over();
        test_simultaneous();
        test_abort_vs_game_over();
        test_rejected();
        test_reset_mid_countdown();
        test_vblnk_high_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/screen_mode_ctrl.md
# screen_mode_ctrl

Frame-synchronous game-state sequencer that drives the `screen_single` / `screen_multi` selects of the background drawer and the gameplay enable for the rest of the pipeline. It sits beside the background drawer on the 65 MHz pixel clock and consumes user/game event pulses and the timing generator's `vblnk`. Every screen change is applied only at the start of vertical blanking, so a frame is never drawn with mixed backgrounds.

## Interface
Parameters:
- `FRAMES_PER_STEP`, 60, frames per countdown step.
- `COUNT_STEPS`, 3, number of countdown steps before play; 1..15.
- `GAMEOVER_FRAMES`, 120, frames the game-over screen is held before returning to idle; ≥1.

Ports:
- `clk65MHz`  in  1  pixel clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vblnk`  in  1  vertical blanking from the timing generator.
- `start_single`  in  1  one-cycle request: start single-player game.
- `start_multi`  in  1  one-cycle request: start multiplayer game.
- `game_over`  in  1  one-cycle pulse from game logic: match ended.
- `abort`  in  1  one-cycle request: return to idle screen.
- `screen_single`  out  1  single-player background select.
- `screen_multi`  out  1  multiplayer background select.
- `game_run`  out  1  gameplay enable; high only in PLAY.
- `countdown_val`  out  4  countdown digit for overlay; 0 outside COUNTDOWN.
- `frame_start`  out  1  one-cycle pulse on the `vblnk` rising edge.

## Operation
- `frame_start` is high for one cycle when the current `vblnk` is 1 and the previous registered `vblnk` was 0.
- Request latching: incoming pulses are captured into pending flags, which hold until consumed at the next `frame_start`. They are cleared on consumption or when the request is rejected.
  - `start_single` / `start_multi` are accepted only in IDLE. If both arrive in the same cycle, single wins.
  - `game_over` is accepted only in PLAY.
  - `abort` is accepted in any non-IDLE state.
  - A rejected request is dropped immediately and never replayed.
- The mode register (`SINGLE` / `MULTI`) is loaded when a start request is consumed. It holds through COUNTDOWN, PLAY and GAME_OVER.
- FSM states and transitions; all transitions occur only on a cycle with `frame_start` = 1:
  - IDLE → COUNTDOWN on a pending start. Load step = `COUNT_STEPS` and frame counter = 0.
  - COUNTDOWN: the frame counter increments each frame. When it reaches `FRAMES_PER_STEP-1`, it resets and step decrements. When step = 1 and the counter wraps, go to PLAY.
  - PLAY → GAME_OVER on pending `game_over`. Frame counter = 0.
  - GAME_OVER → IDLE after `GAMEOVER_FRAMES` frames.
  - Any non-IDLE state → IDLE on pending `abort`. Abort takes priority over `game_over` and over the counter expiring.
- Output decode:
  - `screen_single` = (state ≠ IDLE) & mode = SINGLE.
  - `screen_multi` = (state ≠ IDLE) & mode = MULTI.
  - The two selects are never both 1.
  - `countdown_val` = step in COUNTDOWN, else 0.
- Frame counter width is $clog2(max(`FRAMES_PER_STEP`, `GAMEOVER_FRAMES`)+1). No wrap beyond the terminal value.

## Timing
- Reset values: state IDLE, mode SINGLE, all pending flags 0, counters 0, registered `vblnk` 0. All outputs 0.
- Outputs are registered. They change on the same clock edge that updates the state, i.e. one cycle after the `frame_start` cycle.
- A request arriving in the same cycle as `frame_start` is consumed at that frame start; capture and consumption share the cycle.
- A request arriving after `frame_start` waits up to one frame.
- Reset asserted mid-operation returns to IDLE immediately (asynchronously) and discards all pending requests.
- If `vblnk` is held high through reset release, there is no `frame_start` until its next rising edge.

## Structure
- `game_pkg`: `state_t` enum (IDLE, COUNTDOWN, PLAY, GAME_OVER) and `mode_t` enum (SINGLE, MULTI). The horizontal/vertical constants stay in `vga_pkg`.
- Natural sub-module: `vblnk_edge`, a registered rising-edge detector producing `frame_start`.
- The FSM, pending flags and counters stay in the top-level module.

## Test plan
All scenarios use `FRAMES_PER_STEP`=2, `COUNT_STEPS`=3, `GAMEOVER_FRAMES`=4.
- Single start mid-frame:
  - Pulse `start_single` mid-frame.
  - At the next `frame_start`, `screen_single`=1 and `countdown_val`=3.
  - `countdown_val` is 2 after 2 more frames, then 1.
  - After 6 frames in total, `game_run`=1 with `countdown_val`=0.
- Simultaneous starts: pulse `start_single` and `start_multi` in the same cycle → `screen_single`=1, `screen_multi`=0.
- Game over:
  - Pulse `game_over` in PLAY → `game_run`=0 at the next frame start, screen select still 1.
  - After 4 frames, both selects are 0 (IDLE).
- Abort vs. game over: pulse `abort` and `game_over` in the same PLAY frame → IDLE directly, with no GAME_OVER frames.
- Rejected requests:
  - Pulse `start_multi` in PLAY → ignored. Mode stays SINGLE and no transition occurs after the return to IDLE.
  - Pulse `game_over` in IDLE → no change.
- Reset mid-countdown: drive `rst_n` low with `countdown_val`=2 → all outputs 0 immediately. After release, the FSM stays in IDLE across 3 frames.
